// File: rtl/payload_byte_feeder.sv
// AXI-Stream word to byte serialiser with sod/en/eod framing
// for the character-class decoder and engine NFAs.
module payload_byte_feeder #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
  input  logic                      s_tlast,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  output logic [7:0]                char_out,
  output logic [7:0]                char_lc,
  output logic                      en,
  output logic                      sod,
  output logic                      eod,
  output logic [LEN_WIDTH-1:0]      pkt_len
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOD,
    S_BYTES,
    S_WAIT,
    S_EOD
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_wdat;
  logic [NB-1:0]         r_rkeep;
  logic                  r_rlast;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [7:0]            r_char;
  logic [7:0]            r_lc;
  logic                  r_en;
  logic                  r_sod;
  logic                  r_eod;
  logic [LEN_WIDTH-1:0]  r_len;

  state_t                w_nstate;
  logic [DATA_WIDTH-1:0] w_nwdat;
  logic [NB-1:0]         w_nkeep;
  logic                  w_nlast;
  logic [LEN_WIDTH-1:0]  w_ncnt;
  logic [NB-1:0]         w_clr;
  logic                  w_final;
  logic                  w_acc;
  logic                  w_nen;
  logic [7:0]            w_lane;
  logic [7:0]            w_nchar;
  logic [7:0]            w_nlc;

  assign w_clr   = r_rkeep & (r_rkeep - 1'b1);
  assign w_final = (r_state == S_BYTES) && (w_clr == '0);
  assign s_tready = !rst && ((r_state == S_IDLE) ||
                             (r_state == S_WAIT) ||
                             (w_final && !r_rlast));
  assign w_acc = s_tvalid && s_tready;

  always_comb begin
    w_nstate = r_state;
    w_nwdat  = r_wdat;
    w_nkeep  = r_rkeep;
    w_nlast  = r_rlast;
    w_ncnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_nwdat  = s_tdata;
          w_nkeep  = s_tkeep;
          w_nlast  = s_tlast;
          w_nstate = S_SOD;
        end
      end
      S_SOD: begin
        w_ncnt   = '0;
        w_nstate = S_BYTES;
      end
      S_BYTES: begin
        w_nkeep = w_clr;
        if (r_rkeep != '0 && r_cnt != '1)
          w_ncnt = r_cnt + 1'b1;
        if (w_final) begin
          if (r_rlast) begin
            w_nstate = S_EOD;
          end else if (w_acc) begin
            w_nwdat = s_tdata;
            w_nkeep = s_tkeep;
            w_nlast = s_tlast;
          end else begin
            w_nstate = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (w_acc) begin
          w_nwdat  = s_tdata;
          w_nkeep  = s_tkeep;
          w_nlast  = s_tlast;
          w_nstate = S_BYTES;
        end
      end
      S_EOD:   w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Outputs are registered, so decode what the next state will emit.
  always_comb begin
    w_lane = '0;
    for (int i = NB - 1; i >= 0; i--)
      if (w_nkeep[i]) w_lane = w_nwdat[i*8 +: 8];
    w_nen   = (w_nstate == S_BYTES) && (w_nkeep != '0);
    w_nchar = w_nen ? w_lane : 8'h00;
    w_nlc   = (w_nchar >= 8'h41 && w_nchar <= 8'h5A) ?
              w_nchar + 8'h20 : w_nchar;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wdat  <= '0;
      r_rkeep <= '0;
      r_rlast <= 1'b0;
      r_cnt   <= '0;
      r_char  <= '0;
      r_lc    <= '0;
      r_en    <= 1'b0;
      r_sod   <= 1'b0;
      r_eod   <= 1'b0;
      r_len   <= '0;
    end else begin
      r_state <= w_nstate;
      r_wdat  <= w_nwdat;
      r_rkeep <= w_nkeep;
      r_rlast <= w_nlast;
      r_cnt   <= w_ncnt;
      r_char  <= w_nchar;
      r_lc    <= w_nlc;
      r_en    <= w_nen;
      r_sod   <= (w_nstate == S_SOD);
      r_eod   <= (w_nstate == S_EOD);
      r_len   <= (w_nstate == S_EOD) ? w_ncnt : '0;
    end
  end

  assign char_out = r_char;
  assign char_lc  = r_lc;
  assign en       = r_en;
  assign sod      = r_sod;
  assign eod      = r_eod;
  assign pkt_len  = r_len;

endmodule

// File: doc/payload_byte_feeder.md
# payload_byte_feeder

Front end of the payload engine array: accepts packet payload as an AXI-Stream word stream and serialises it to one byte per clock for the character-class decoder and the per-rule `engine_*` NFAs. It also generates the per-packet framing strobes those engines rely on:
- `sod` clears the NFA state registers before the first byte.
- `en` qualifies each byte.
- `eod` marks the cycle on which downstream match latches are sampled.

## Interface
Parameters:
- `DATA_WIDTH`, 64: input word width; multiple of 8; `NBYTES = DATA_WIDTH/8`.
- `LEN_WIDTH`, 16: width of packet byte counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_tdata`  in  DATA_WIDTH  payload word; lane 0 = `[7:0]` = first byte.
- `s_tkeep`  in  NBYTES  lane valid mask; lanes with 0 are skipped; need not be contiguous.
- `s_tlast`  in  1  last word of packet.
- `s_tvalid`  in  1  word valid.
- `s_tready`  out  1  word accepted when `s_tvalid & s_tready`.
- `char_out`  out  8  current payload byte.
- `char_lc`  out  8  `char_out` case-folded: 0x41–0x5A mapped to +0x20; all other values unchanged.
- `en`  out  1  `char_out`/`char_lc` valid this cycle; drives engine `en`.
- `sod`  out  1  one-cycle start-of-data pulse; drives engine `sod`.
- `eod`  out  1  one-cycle end-of-data pulse.
- `pkt_len`  out  LEN_WIDTH  bytes emitted in packet; valid while `eod`=1.

## Operation
- Internal state: word register `wdat`, remaining-lane mask `rkeep`, last flag `rlast`, counter `cnt`, FSM state.
- FSM states and transitions:
  - IDLE: `s_tready`=1. On accept, load `wdat`/`rkeep`/`rlast` and go to SOD.
  - SOD: `sod`=1, `en`=0, `s_tready`=0; lasts 1 cycle. Clear `cnt`, then go to BYTES.
  - BYTES: if `rkeep`≠0, emit the lowest set lane:
    - `char_out` = that lane, `en`=1, clear that bit, `cnt`+1.
    - `cnt` saturates at 2^LEN_WIDTH−1; it never wraps.
  - Final-lane condition: the emitted lane was the last set bit, or `rkeep`=0 on entry (zero-keep word, `en`=0). Then:
    - if `rlast`: go to EOD, `s_tready`=0;
    - else: `s_tready`=1 this cycle. On accept, load the next word and stay in BYTES, giving back-to-back bytes with no bubble. Otherwise go to WAIT.
  - `s_tready`=0 in BYTES when the final-lane condition does not hold.
  - WAIT: `s_tready`=1, `en`=0. On accept, load the word and go to BYTES.
  - EOD: `eod`=1, `pkt_len`=`cnt`, `en`=0, `s_tready`=0; lasts 1 cycle, then go to IDLE.
- `sod` and `eod` are never asserted together with `en`, and never with each other.
- A packet whose every word has `tkeep`=0 yields SOD, then EOD, with `pkt_len`=0.
- There is no downstream backpressure; engines accept one byte per enabled cycle unconditionally.

## Timing
- Reset: while `rst`=1, `s_tready`=0. On the cycle after deassertion, the FSM is in IDLE and all outputs are 0 except `s_tready`=1.
- Reset mid-packet abandons the packet immediately: no `eod`, held word discarded.
- Outputs `char_out`, `char_lc`, `en`, `sod`, `eod` and `pkt_len` are registered.
- `s_tready` is a combinational decode of FSM state and `rkeep` only, never of `s_tvalid`.
- Latency from an accept in IDLE at cycle t:
  - `sod` at t+1;
  - first `en` at t+2;
  - a k-byte single-word packet has `en` at t+2..t+k+1 and `eod` at t+k+2.
- Throughput: 1 byte/cycle while input words arrive without gaps.
- Per-packet overhead: 2 idle cycles (SOD, EOD), plus 1 cycle for the IDLE accept.
- Back-to-back packets: next accept occurs in IDLE at the cycle after EOD, so minimum inter-packet gap is 3 cycles with `en`=0.
- `s_tvalid` drop mid-packet: WAIT holds indefinitely, `en`=0, NFA state preserved.

## Test plan
- Single word, `tkeep`=0xFF, `tlast`=1, data bytes "location" (lane 0 = 'l'): `sod` at t+1; `en` for 8 cycles emitting l,o,c,a,t,i,o,n; `eod` with `pkt_len`=8 at t+10.
- Two words, keep 0xFF then 0x07, second `tlast`=1, `s_tvalid` continuous: 11 consecutive `en` cycles, no bubble at the word boundary; `pkt_len`=11.
- Sparse keep 0xA5 on data 0x0706050403020100: bytes emitted in order 0x00, 0x02, 0x05, 0x07; `pkt_len`=4.
- Case fold: bytes 0x41, 0x5A, 0x5B, 0x61, 0x40 give `char_lc` = 0x61, 0x7A, 0x5B, 0x61, 0x40.
- Zero-keep last word after a 3-byte word: 3 `en`, then `eod`, `pkt_len`=3. A lone zero-keep packet gives `sod`, then `eod`, `pkt_len`=0.
- Stall and reset:
  - `s_tvalid` low for 5 cycles between words: `en`=0 in WAIT and output resumes cleanly afterwards.
  - `rst` asserted during byte 2 of a 5-byte packet: no `eod`, all outputs 0 the next cycle.
  - Next packet starts from IDLE with `sod`.
